dac_spi_ctrl: RTL and testbench
===============================

# dac_spi_ctrl

Serial DAC driver sitting between the ASIC function interface register file and the external DAC pins (DAC_CS_N, DAC_LDAC_N, DAC_DIN, DAC_SCLK). On a one-cycle start strobe it latches a data word and shifts it MSB-first over an SPI-style link. It then pulses LDAC to update the analog output and reports completion with a one-cycle done pulse. The register file drives `start` from its control-register write and `din` from its data-out register.

## Interface
- DATA_WIDTH, 16, bits per DAC frame
- CLK_DIV, 4, clk cycles per SCLK half-period (≥1)
- LDAC_CYCLES, 2, clk cycles DAC_LDAC_N is held low (≥1)
- clk  in  1  system clock; all logic on rising edge
- rst  in  1  asynchronous, active-high reset
- din  in  DATA_WIDTH  word to send; sampled only when a start is accepted
- start  in  1  request strobe; accepted only in IDLE
- busy  out  1  high from the cycle after acceptance through the end of LDAC
- done  out  1  one-cycle pulse when the frame and LDAC pulse are complete
- DAC_CS_N  out  1  chip select, active low
- DAC_SCLK  out  1  serial clock, idles low
- DAC_DIN  out  1  serial data; changes on SCLK falling edges, DAC samples on rising edges
- DAC_LDAC_N  out  1  load-DAC strobe, active low

## Operation
- All outputs are registered. Reset values: CS_N=1, SCLK=0, DIN=0, LDAC_N=1, busy=0, done=0, state=IDLE.
- States: IDLE → SETUP → SHIFT → HOLD → LDAC → IDLE.
- IDLE: if start=1 at an edge, load shreg←din, DIN←din[MSB], CS_N←0, busy←1, enter SETUP. Otherwise start is ignored. The done pulse cycle is IDLE, so start there is accepted.
- SETUP: CS_N low and SCLK low for CLK_DIV cycles, then enter SHIFT.
- SHIFT: each bit is SCLK high for CLK_DIV cycles, then low for CLK_DIV cycles.
  - On each SCLK falling edge, shreg shifts left and DIN presents the next bit.
  - Bit counter runs 0..DATA_WIDTH-1.
  - After the low phase of the last bit, enter HOLD. DIN holds the last bit.
- HOLD: CS_N low and SCLK low for CLK_DIV cycles. Then CS_N←1, LDAC_N←0, enter LDAC.
- LDAC: LDAC_N low for LDAC_CYCLES cycles. Then LDAC_N←1, busy←0, done←1 (one cycle), enter IDLE.
- start while busy=1 is dropped. There is no queueing and no error flag.
- din changes while busy have no effect on the frame in flight.

## Timing
- Start accepted at edge k: CS_N, busy and DIN=MSB are valid after edge k.
- First SCLK rise at k+CLK_DIV.
- SCLK rise n (n=0..DATA_WIDTH-1) at k+CLK_DIV·(1+2n).
- CS_N rises at k+CLK_DIV·(2+2·DATA_WIDTH). LDAC_N falls on the same edge.
- done high for the one cycle after edge k+CLK_DIV·(2+2·DATA_WIDTH)+LDAC_CYCLES. Busy falls on the same edge.
- Defaults give 138 busy cycles.
- Back-to-back: start held high gives a new CS_N fall on the same edge done rises. CS_N high time between frames is then LDAC_CYCLES cycles.
- Reset mid-frame: outputs return to reset values asynchronously. No LDAC pulse and no done are issued, and the partial frame is discarded.
- Divider counter width is $clog2(CLK_DIV+1). Bit counter width is $clog2(DATA_WIDTH). CLK_DIV=1 gives SCLK = clk/2.

## Structure
- Package dac_spi_pkg holds:
  - state enum (IDLE, SETUP, SHIFT, HOLD, LDAC);
  - default constants DAC_DATA_WIDTH=16, DAC_CLK_DIV=4, DAC_LDAC_CYCLES=2.
- One sub-module, dac_sclk_div: a down-counter that reloads CLK_DIV-1 and emits a one-cycle `tick` each half-period. It is enabled only outside IDLE and cleared on state entry. The FSM advances phases on `tick`.

## Test plan
- Reset: hold rst 3 cycles, then release → CS_N=1, LDAC_N=1, SCLK=0, busy=0 throughout; no SCLK edges.
- Single frame: din=16'hA5C3, start for 1 cycle, defaults → 16 SCLK rises; bits captured on rising edges = A5C3 MSB-first; CS_N low for 136 cycles; LDAC_N low 2 cycles after CS_N rises; done 1 cycle at start+138; busy=1 for exactly 138 cycles.
- Sweep as the register file drives it: din=16'h0000, 16'h1000 … 16'hF000, each followed by a wait for done → each captured word equals din; exactly 16 done pulses.
- Ignored start: start pulse at cycle 40 of a frame with din=16'hFFFF (frame in flight was 16'h0001) → captured word 16'h0001; no second frame; single done.
- Back-to-back: start held high, din=16'h1234 then 16'h5678 → CS_N re-falls the cycle done asserts; CS_N high gap = 2 cycles; both words captured intact.
- Reset mid-frame: assert rst at bit 7 of din=16'hBEEF → CS_N=1 and SCLK=0 immediately; LDAC_N never low; no done. A subsequent start with din=16'h00FF sends 00FF cleanly.
- CLK_DIV=1, DATA_WIDTH=12 build: din=12'hABC → SCLK period 2 cycles; captured 12'hABC; busy=1·(2+24)+2=28 cycles.

Source files
------------

// File: rtl/dac_spi_pkg.sv
// Shared types and default sizing for the serial DAC driver.
// Holds the frame FSM state encoding and the default frame/timing constants.
package dac_spi_pkg;

    localparam int DAC_DATA_WIDTH  = 16;
    localparam int DAC_CLK_DIV     = 4;
    localparam int DAC_LDAC_CYCLES = 2;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        SHIFT,
        HOLD,
        LDAC
    } state_t;

endpackage

// File: rtl/dac_sclk_div.sv
// Half-period timebase for the DAC serial clock.
// Ports: clk, rst (async, active high), en (count enable), clr (reload on
// state entry), tick (one-cycle pulse at the end of each half-period).
module dac_sclk_div #(
    parameter int CLK_DIV = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic clr,
    output logic tick
);

    localparam int CW = $clog2(CLK_DIV + 1);
    localparam logic [CW-1:0] RELOAD = CW'(CLK_DIV - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    always_comb begin
        tick  = en && (cnt_q == '0);
        cnt_d = cnt_q - 1'b1;
        // Held at the reload value while disabled so the first half-period
        // after leaving IDLE is a full CLK_DIV cycles long.
        if (!en || clr || tick) begin
            cnt_d = RELOAD;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= RELOAD;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/dac_spi_ctrl.sv
// Serial DAC driver: latches din on start, shifts it MSB-first, pulses LDAC.
// Ports: clk, rst (async, active high), din, start -> busy, done, DAC_CS_N,
// DAC_SCLK, DAC_DIN, DAC_LDAC_N (all outputs registered).
module dac_spi_ctrl
    import dac_spi_pkg::*;
#(
    parameter int DATA_WIDTH  = DAC_DATA_WIDTH,
    parameter int CLK_DIV     = DAC_CLK_DIV,
    parameter int LDAC_CYCLES = DAC_LDAC_CYCLES
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] din,
    input  logic                  start,
    output logic                  busy,
    output logic                  done,
    output logic                  DAC_CS_N,
    output logic                  DAC_SCLK,
    output logic                  DAC_DIN,
    output logic                  DAC_LDAC_N
);

    localparam int BW = $clog2(DATA_WIDTH);
    localparam int LW = $clog2(LDAC_CYCLES + 1);
    localparam logic [BW-1:0] LAST_BIT = BW'(DATA_WIDTH - 1);
    localparam logic [LW-1:0] LDAC_RELOAD = LW'(LDAC_CYCLES - 1);

    state_t                state_q, state_d;
    logic [DATA_WIDTH-1:0] shreg_q, shreg_d;
    logic [BW-1:0]         bit_cnt_q, bit_cnt_d;
    logic [LW-1:0]         ldac_cnt_q, ldac_cnt_d;
    logic                  cs_n_q, cs_n_d;
    logic                  sclk_q, sclk_d;
    logic                  dout_q, dout_d;
    logic                  ldac_n_q, ldac_n_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;

    logic tick;
    logic div_en;
    logic div_clr;

    assign div_en  = (state_q != IDLE);
    assign div_clr = (state_d != state_q);

    dac_sclk_div #(
        .CLK_DIV(CLK_DIV)
    ) u_div (
        .clk (clk),
        .rst (rst),
        .en  (div_en),
        .clr (div_clr),
        .tick(tick)
    );

    always_comb begin
        state_d    = state_q;
        shreg_d    = shreg_q;
        bit_cnt_d  = bit_cnt_q;
        ldac_cnt_d = ldac_cnt_q;
        cs_n_d     = cs_n_q;
        sclk_d     = sclk_q;
        dout_d     = dout_q;
        ldac_n_d   = ldac_n_q;
        busy_d     = busy_q;
        done_d     = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    shreg_d   = din;
                    dout_d    = din[DATA_WIDTH-1];
                    cs_n_d    = 1'b0;
                    busy_d    = 1'b1;
                    bit_cnt_d = '0;
                    state_d   = SETUP;
                end
            end
            SETUP: begin
                if (tick) begin
                    sclk_d  = 1'b1;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                if (tick) begin
                    if (sclk_q) begin
                        sclk_d = 1'b0;
                        // The last bit stays on DIN through HOLD.
                        if (bit_cnt_q != LAST_BIT) begin
                            shreg_d = shreg_q << 1;
                            dout_d  = shreg_q[DATA_WIDTH-2];
                        end
                    end else if (bit_cnt_q == LAST_BIT) begin
                        state_d = HOLD;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 1'b1;
                        sclk_d    = 1'b1;
                    end
                end
            end
            HOLD: begin
                if (tick) begin
                    cs_n_d     = 1'b1;
                    ldac_n_d   = 1'b0;
                    ldac_cnt_d = LDAC_RELOAD;
                    state_d    = LDAC;
                end
            end
            LDAC: begin
                ldac_cnt_d = ldac_cnt_q - 1'b1;
                if (ldac_cnt_q == '0) begin
                    ldac_n_d = 1'b1;
                    busy_d   = 1'b0;
                    done_d   = 1'b1;
                    state_d  = IDLE;
                    // A start present on the closing edge chains straight
                    // into the next frame, so CS_N high lasts LDAC_CYCLES.
                    if (start) begin
                        shreg_d   = din;
                        dout_d    = din[DATA_WIDTH-1];
                        cs_n_d    = 1'b0;
                        busy_d    = 1'b1;
                        bit_cnt_d = '0;
                        state_d   = SETUP;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            shreg_q    <= '0;
            bit_cnt_q  <= '0;
            ldac_cnt_q <= '0;
            cs_n_q     <= 1'b1;
            sclk_q     <= 1'b0;
            dout_q     <= 1'b0;
            ldac_n_q   <= 1'b1;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            shreg_q    <= shreg_d;
            bit_cnt_q  <= bit_cnt_d;
            ldac_cnt_q <= ldac_cnt_d;
            cs_n_q     <= cs_n_d;
            sclk_q     <= sclk_d;
            dout_q     <= dout_d;
            ldac_n_q   <= ldac_n_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign busy       = busy_q;
    assign done       = done_q;
    assign DAC_CS_N   = cs_n_q;
    assign DAC_SCLK   = sclk_q;
    assign DAC_DIN    = dout_q;
    assign DAC_LDAC_N = ldac_n_q;

endmodule

// File: tb/tb_dac_spi_ctrl.sv
// Bench for dac_spi_ctrl: default build (a) plus a CLK_DIV=1, 12-bit build (b).
// Words captured off the pins on SCLK rises are scored against expected words.
module tb_dac_spi_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [15:0] din_a = '0;
    logic        start_a = 1'b0;
    logic        busy_a, done_a, cs_n_a, sclk_a, dout_a, ldac_n_a;

    logic [11:0] din_b = '0;
    logic        start_b = 1'b0;
    logic        busy_b, done_b, cs_n_b, sclk_b, dout_b, ldac_n_b;

    dac_spi_ctrl u_dut_a (
        .clk       (clk),
        .rst       (rst),
        .din       (din_a),
        .start     (start_a),
        .busy      (busy_a),
        .done      (done_a),
        .DAC_CS_N  (cs_n_a),
        .DAC_SCLK  (sclk_a),
        .DAC_DIN   (dout_a),
        .DAC_LDAC_N(ldac_n_a)
    );

    dac_spi_ctrl #(
        .DATA_WIDTH (12),
        .CLK_DIV    (1),
        .LDAC_CYCLES(2)
    ) u_dut_b (
        .clk       (clk),
        .rst       (rst),
        .din       (din_b),
        .start     (start_b),
        .busy      (busy_b),
        .done      (done_b),
        .DAC_CS_N  (cs_n_b),
        .DAC_SCLK  (sclk_b),
        .DAC_DIN   (dout_b),
        .DAC_LDAC_N(ldac_n_b)
    );

    int pass_cnt = 0;
    int chk_cnt  = 0;

    logic [15:0] exp_a_q[$];
    logic [15:0] got_a_q[$];
    logic [11:0] exp_b_q[$];
    logic [11:0] got_b_q[$];

    logic [15:0] cap_a = '0, last_word_a = '0;
    int          bits_a = 0, last_bits_a = 0, rises_a = 0, done_cnt_a = 0;
    logic [11:0] cap_b = '0, last_word_b = '0;
    int          bits_b = 0, last_bits_b = 0, done_cnt_b = 0;

    always @(negedge cs_n_a) begin cap_a = '0; bits_a = 0; end
    always @(posedge sclk_a) begin
        cap_a = {cap_a[14:0], dout_a};
        bits_a++;
        rises_a++;
    end
    always @(posedge cs_n_a) begin last_word_a = cap_a; last_bits_a = bits_a; end
    always @(negedge clk) if (done_a === 1'b1) begin
        got_a_q.push_back(last_word_a);
        done_cnt_a++;
    end

    always @(negedge cs_n_b) begin cap_b = '0; bits_b = 0; end
    always @(posedge sclk_b) begin cap_b = {cap_b[10:0], dout_b}; bits_b++; end
    always @(posedge cs_n_b) begin last_word_b = cap_b; last_bits_b = bits_b; end
    always @(negedge clk) if (done_b === 1'b1) begin
        got_b_q.push_back(last_word_b);
        done_cnt_b++;
    end

    task automatic pulse_a(input logic [15:0] d);
        @(negedge clk);
        din_a   = d;
        start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
    endtask

    task automatic wait_done_a(input int max);
        for (int i = 0; i < max; i++) begin
            @(negedge clk);
            if (done_a === 1'b1) break;
        end
        #1;
    endtask

    task automatic test_reset();
        int r0;
        int bad;
        rst = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk_cnt++;
            if ({cs_n_a, ldac_n_a, sclk_a, busy_a, done_a, dout_a} !== 6'b110000)
                $display("FAIL reset_hold: pins=%b want 110000",
                         {cs_n_a, ldac_n_a, sclk_a, busy_a, done_a, dout_a});
            else pass_cnt++;
        end
        rst = 1'b0;
        r0  = rises_a;
        bad = 0;
        repeat (6) begin
            @(negedge clk);
            if ({cs_n_a, ldac_n_a, sclk_a, busy_a} !== 4'b1100) bad++;
        end
        chk_cnt++;
        if (bad != 0) $display("FAIL reset_idle: bad cycles=%0d want 0", bad);
        else pass_cnt++;
        chk_cnt++;
        if (rises_a != r0) $display("FAIL reset_sclk: rises=%0d want 0", rises_a - r0);
        else pass_cnt++;
    endtask

    task automatic test_single_frame();
        int k, d0, busy_n, cs_low, ldac_low, t_csr, t_ldac, t_done;
        logic [15:0] w, e;
        d0 = done_cnt_a;
        exp_a_q.push_back(16'hA5C3);
        pulse_a(16'hA5C3);
        k = cyc;
        chk_cnt++;
        if ({busy_a, cs_n_a, dout_a} !== 3'b101)
            $display("FAIL single_accept: busy,cs_n,din=%b want 101", {busy_a, cs_n_a, dout_a});
        else pass_cnt++;
        busy_n = 1; cs_low = 1; ldac_low = 0;
        t_csr = -1; t_ldac = -1; t_done = -1;
        for (int i = 0; i < 300 && t_done < 0; i++) begin
            @(negedge clk);
            if (busy_a) busy_n++;
            if (!cs_n_a) cs_low++;
            else if (t_csr < 0) t_csr = cyc;
            if (!ldac_n_a) begin
                ldac_low++;
                if (t_ldac < 0) t_ldac = cyc;
            end
            if (done_a) t_done = cyc;
        end
        chk_cnt++;
        if (busy_n != 138) $display("FAIL single_busy: cycles=%0d want 138", busy_n);
        else pass_cnt++;
        chk_cnt++;
        if (cs_low != 136) $display("FAIL single_cs_low: cycles=%0d want 136", cs_low);
        else pass_cnt++;
        chk_cnt++;
        if (t_csr - k != 136) $display("FAIL single_cs_rise: at=%0d want 136", t_csr - k);
        else pass_cnt++;
        chk_cnt++;
        if (t_ldac - k != 136 || ldac_low != 2)
            $display("FAIL single_ldac: at=%0d len=%0d want 136 2", t_ldac - k, ldac_low);
        else pass_cnt++;
        chk_cnt++;
        if (t_done - k != 138) $display("FAIL single_done_time: at=%0d want 138", t_done - k);
        else pass_cnt++;
        #1;
        chk_cnt++;
        if (got_a_q.size() == 0 || exp_a_q.size() == 0)
            $display("FAIL single_word: got none want A5C3");
        else begin
            w = got_a_q.pop_front();
            e = exp_a_q.pop_front();
            if (w !== e) $display("FAIL single_word: got %h want %h", w, e);
            else pass_cnt++;
        end
        chk_cnt++;
        if (last_bits_a != 16) $display("FAIL single_rises: got %0d want 16", last_bits_a);
        else pass_cnt++;
        @(negedge clk);
        chk_cnt++;
        if (done_a !== 1'b0 || done_cnt_a - d0 != 1)
            $display("FAIL single_done_pulse: done=%b pulses=%0d want 0 1", done_a, done_cnt_a - d0);
        else pass_cnt++;
    endtask

    task automatic test_sweep();
        int d0;
        logic [15:0] w, e, d;
        d0 = done_cnt_a;
        for (int i = 0; i < 16; i++) begin
            d = 16'(i) << 12;
            exp_a_q.push_back(d);
            pulse_a(d);
            wait_done_a(200);
            chk_cnt++;
            if (got_a_q.size() == 0 || exp_a_q.size() == 0)
                $display("FAIL sweep_word: got none want %h", d);
            else begin
                w = got_a_q.pop_front();
                e = exp_a_q.pop_front();
                if (w !== e) $display("FAIL sweep_word: got %h want %h", w, e);
                else pass_cnt++;
            end
        end
        chk_cnt++;
        if (done_cnt_a - d0 != 16) $display("FAIL sweep_done: got %0d want 16", done_cnt_a - d0);
        else pass_cnt++;
    endtask

    task automatic test_ignored_start();
        int d0, busy_n;
        logic [15:0] w, e;
        d0 = done_cnt_a;
        exp_a_q.push_back(16'h0001);
        pulse_a(16'h0001);
        repeat (38) @(negedge clk);
        pulse_a(16'hFFFF);
        wait_done_a(200);
        chk_cnt++;
        if (got_a_q.size() == 0 || exp_a_q.size() == 0)
            $display("FAIL ignored_word: got none want 0001");
        else begin
            w = got_a_q.pop_front();
            e = exp_a_q.pop_front();
            if (w !== e) $display("FAIL ignored_word: got %h want %h", w, e);
            else pass_cnt++;
        end
        busy_n = 0;
        repeat (200) begin
            @(negedge clk);
            if (busy_a !== 1'b0) busy_n++;
        end
        chk_cnt++;
        if (busy_n != 0 || done_cnt_a - d0 != 1)
            $display("FAIL ignored_extra: busy=%0d dones=%0d want 0 1", busy_n, done_cnt_a - d0);
        else pass_cnt++;
    endtask

    task automatic test_back_to_back();
        int d0, gap, busy_n;
        logic [15:0] w, e;
        d0 = done_cnt_a;
        exp_a_q.push_back(16'h1234);
        exp_a_q.push_back(16'h5678);
        @(negedge clk);
        din_a   = 16'h1234;
        start_a = 1'b1;
        @(negedge clk);
        din_a = 16'h5678;
        gap = 0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (done_a === 1'b1) break;
            if (cs_n_a) gap++;
        end
        chk_cnt++;
        if (done_a !== 1'b1 || cs_n_a !== 1'b0)
            $display("FAIL b2b_refall: done,cs_n=%b want 10", {done_a, cs_n_a});
        else pass_cnt++;
        start_a = 1'b0;
        chk_cnt++;
        if (gap != 2) $display("FAIL b2b_gap: got %0d want 2", gap);
        else pass_cnt++;
        wait_done_a(200);
        for (int j = 0; j < 2; j++) begin
            chk_cnt++;
            if (got_a_q.size() == 0 || exp_a_q.size() == 0)
                $display("FAIL b2b_word: got none for frame %0d", j);
            else begin
                w = got_a_q.pop_front();
                e = exp_a_q.pop_front();
                if (w !== e) $display("FAIL b2b_word: got %h want %h", w, e);
                else pass_cnt++;
            end
        end
        busy_n = 0;
        repeat (160) begin
            @(negedge clk);
            if (busy_a !== 1'b0) busy_n++;
        end
        chk_cnt++;
        if (busy_n != 0 || done_cnt_a - d0 != 2)
            $display("FAIL b2b_extra: busy=%0d dones=%0d want 0 2", busy_n, done_cnt_a - d0);
        else pass_cnt++;
    endtask

    task automatic test_reset_mid_frame();
        int d0, ldac_seen;
        logic [15:0] w, e;
        d0 = done_cnt_a;
        ldac_seen = 0;
        pulse_a(16'hBEEF);
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (!ldac_n_a) ldac_seen++;
            if (bits_a >= 8) break;
        end
        #2;
        rst = 1'b1;
        #1;
        chk_cnt++;
        if ({cs_n_a, sclk_a, ldac_n_a, busy_a, dout_a} !== 5'b10100)
            $display("FAIL midrst_pins: cs,sclk,ldac,busy,din=%b want 10100",
                     {cs_n_a, sclk_a, ldac_n_a, busy_a, dout_a});
        else pass_cnt++;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (20) begin
            @(negedge clk);
            if (!ldac_n_a) ldac_seen++;
        end
        chk_cnt++;
        if (ldac_seen != 0 || done_cnt_a != d0)
            $display("FAIL midrst_quiet: ldac=%0d dones=%0d want 0 0", ldac_seen, done_cnt_a - d0);
        else pass_cnt++;
        exp_a_q.push_back(16'h00FF);
        pulse_a(16'h00FF);
        wait_done_a(200);
        chk_cnt++;
        if (got_a_q.size() == 0 || exp_a_q.size() == 0)
            $display("FAIL midrst_word: got none want 00FF");
        else begin
            w = got_a_q.pop_front();
            e = exp_a_q.pop_front();
            if (w !== e || last_bits_a != 16)
                $display("FAIL midrst_word: got %h/%0d want %h/16", w, last_bits_a, e);
            else pass_cnt++;
        end
    endtask

    task automatic test_fast_narrow();
        int k, busy_n, hi_n, t_done;
        logic [11:0] w, e;
        exp_b_q.push_back(12'hABC);
        @(negedge clk);
        din_b   = 12'hABC;
        start_b = 1'b1;
        @(negedge clk);
        start_b = 1'b0;
        k = cyc;
        busy_n = 1; hi_n = 0; t_done = -1;
        for (int i = 0; i < 100 && t_done < 0; i++) begin
            @(negedge clk);
            if (busy_b) busy_n++;
            if (sclk_b) hi_n++;
            if (done_b) t_done = cyc;
        end
        chk_cnt++;
        if (busy_n != 28 || t_done - k != 28)
            $display("FAIL fast_busy: cycles=%0d done_at=%0d want 28 28", busy_n, t_done - k);
        else pass_cnt++;
        chk_cnt++;
        if (hi_n != 12 || last_bits_b != 12)
            $display("FAIL fast_sclk: high=%0d rises=%0d want 12 12", hi_n, last_bits_b);
        else pass_cnt++;
        #1;
        chk_cnt++;
        if (got_b_q.size() == 0 || exp_b_q.size() == 0)
            $display("FAIL fast_word: got none want ABC");
        else begin
            w = got_b_q.pop_front();
            e = exp_b_q.pop_front();
            if (w !== e) $display("FAIL fast_word: got %h want %h", w, e);
            else pass_cnt++;
        end
    endtask

    initial begin
        test_reset();
        test_single_frame();
        test_sweep();
        test_ignored_start();
        test_back_to_back();
        test_reset_mid_frame();
        test_fast_narrow();
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
